// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD converter (shift-and-add-3, one
// binary bit per clock). A single shared add-3 correction slice replaces the
// combinational correction array. The digit outputs are registered and hold
// the previous result while a new operand converts.
//
// Optional feature macro: BCD_SEQ_BLANK_EN
//   defined   : tens_blank / hund_blank are registered leading-zero flags,
//               updated together with the digits and reset to 1.
//   undefined : tens_blank / hund_blank are tied to 0 (no flag registers).
//
// Ports
//   CLOCK_50    in   1      single clock, all state updates on rising edge
//   reset       in   1      synchronous, active-high reset
//   start       in   1      conversion request, sampled only while idle
//   bin         in   WIDTH  binary operand, captured on the accepting edge
//   busy        out  1      high while a conversion is in flight
//   done        out  1      one-cycle pulse, digits were just updated
//   ones        out  4      BCD units digit
//   tens        out  4      BCD tens digit
//   hundreds    out  4      BCD hundreds digit
//   tens_blank  out  1      tens digit is a leading zero (feature only)
//   hund_blank  out  1      hundreds digit is a leading zero (feature only)
//
// WIDTH legal range is 4..9 so the result always fits in three BCD digits.

module bcd_seq_conv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic             tens_blank,
  output logic             hund_blank
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 12;
  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  // Control and datapath state
  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Registered outputs
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [NIB_W-1:0] ones_q,     ones_d;
  logic [NIB_W-1:0] tens_q,     tens_d;
  logic [NIB_W-1:0] hundreds_q, hundreds_d;

  // Scratch after the per-nibble add-3 correction, before the shift
  logic [BCD_W-1:0] scratch_adj;

  // Add 3 to a BCD nibble that is 5 or more; no carry leaves the nibble
  function automatic logic [NIB_W-1:0] add3(input logic [NIB_W-1:0] nib);
    logic [NIB_W-1:0] res;
    res = nib;
    if (nib >= NIB_W'(5)) begin
      res = nib + NIB_W'(3);
    end
    return res;
  endfunction

  // Shared correction slice applied to all three nibbles in parallel
  always_comb begin
    scratch_adj = '0;
    for (int n = 0; n < 3; n++) begin
      scratch_adj[n*NIB_W +: NIB_W] = add3(scratch_q[n*NIB_W +: NIB_W]);
    end
  end

  // State and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      hundreds_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // {scratch, shreg} shifts left by one after correction; the
        // corrected hundreds MSB falls off the top (always 0 for WIDTH <= 9)
        scratch_d = BCD_W'({scratch_adj, shreg_q[WIDTH-1]});
        shreg_d   = WIDTH'({shreg_q, 1'b0});
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ones_d     = scratch_q[3:0];
        tens_d     = scratch_q[7:4];
        hundreds_d = scratch_q[11:8];
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy mirrors the next state so it is aligned with SHIFT/LOAD
    busy_d = (state_d != ST_IDLE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;

`ifdef BCD_SEQ_BLANK_EN
  logic tens_blank_q, tens_blank_d;
  logic hund_blank_q, hund_blank_d;

  // Leading-zero flags captured with the digits; blank after reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tens_blank_q <= 1'b1;
      hund_blank_q <= 1'b1;
    end else begin
      tens_blank_q <= tens_blank_d;
      hund_blank_q <= hund_blank_d;
    end
  end

  always_comb begin
    tens_blank_d = tens_blank_q;
    hund_blank_d = hund_blank_q;
    if (state_q == ST_LOAD) begin
      hund_blank_d = (scratch_q[11:8] == NIB_W'(0));
      tens_blank_d = (scratch_q[11:4] == 8'd0);
    end
  end

  assign tens_blank = tens_blank_q;
  assign hund_blank = hund_blank_q;
`else
  assign tens_blank = 1'b0;
  assign hund_blank = 1'b0;
`endif

endmodule
